// File: rtl/bus_arbiter_2m8s.sv
// bus_arbiter_2m8s
// Two-master / eight-slave bus controller. Arbitrates bus ownership between
// M0 and M1 (alternating priority on ties), muxes the granted master's
// address / write-enable / write-data onto the shared slave bus, decodes the
// top three address bits into a one-hot slave select, and registers the
// read-mux select that steers the external 8:1 read-data mux back to the
// masters.
//
// Optional feature: define BUS_HOLD_LIMIT_EN to bound a master's tenure to
// HOLD_MAX consecutive grant cycles whenever the other master is waiting.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   m0_* / m1_*         per-master req, wr, addr, write data (dout)
//   m0_grant, m1_grant  bus ownership
//   s_addr, s_wr, s_din shared slave bus
//   s_sel               one-hot slave select
//   m_rsel, rd_valid    registered read-mux select and read-data valid
module bus_arbiter_2m8s #(
  parameter int ADDR_W   = 16,
  parameter int HOLD_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wr,
  output logic [31:0]       s_din,
  output logic [7:0]        s_sel,
  output logic [2:0]        m_rsel,
  output logic              rd_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t     r_state, w_next;
  logic       r_last_gnt;   // 0 = M0 had the bus last, 1 = M1
  logic [2:0] r_rsel;
  logic       r_rd_valid;
  logic       w_greq;       // granted master still requesting
  logic       w_mwr;        // granted master's raw write flag
  logic [2:0] w_idx;
  logic       w_hold_exp;   // current owner must yield if the other waits

`ifdef BUS_HOLD_LIMIT_EN
  localparam int CW = $clog2(HOLD_MAX) + 1;
  logic [CW-1:0] r_hold_cnt;
  assign w_hold_exp = (r_hold_cnt == CW'(HOLD_MAX - 1));
`else
  assign w_hold_exp = 1'b0;
`endif

  // Next-state: a waiting master takes over directly from the other grant
  // state (no IDLE bubble) once the owner drops req or its tenure expires.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) w_next = r_last_gnt ? GNT0 : GNT1;
        else if (m0_req)      w_next = GNT0;
        else if (m1_req)      w_next = GNT1;
      end
      GNT0: begin
        if (m1_req && (!m0_req || w_hold_exp)) w_next = GNT1;
        else if (!m0_req)                      w_next = IDLE;
      end
      GNT1: begin
        if (m0_req && (!m1_req || w_hold_exp)) w_next = GNT0;
        else if (!m1_req)                      w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus mux and decode, purely from the registered state.
  always_comb begin
    s_addr = '0;
    s_din  = '0;
    w_mwr  = 1'b0;
    w_greq = 1'b0;
    case (r_state)
      GNT0: begin s_addr = m0_addr; s_din = m0_dout; w_mwr = m0_wr; w_greq = m0_req; end
      GNT1: begin s_addr = m1_addr; s_din = m1_dout; w_mwr = m1_wr; w_greq = m1_req; end
      default: ;
    endcase
  end

  assign w_idx    = s_addr[ADDR_W-1 -: 3];
  assign s_sel    = w_greq ? (8'b1 << w_idx) : 8'h00;
  // A write strobe without a select would be meaningless to the slaves.
  assign s_wr     = w_mwr & w_greq;
  assign m0_grant = (r_state == GNT0);
  assign m1_grant = (r_state == GNT1);
  assign m_rsel   = r_rsel;
  assign rd_valid = r_rd_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_rsel     <= 3'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == GNT0 && r_state != GNT0) r_last_gnt <= 1'b0;
      if (w_next == GNT1 && r_state != GNT1) r_last_gnt <= 1'b1;
      // Read data shows up at the mux one cycle after the select cycle;
      // m_rsel holds between reads so the mux output stays stable.
      if (w_greq && !w_mwr) begin
        r_rsel     <= w_idx;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

`ifdef BUS_HOLD_LIMIT_EN
  // Saturates at HOLD_MAX-1 so a long uncontended tenure yields as soon as
  // the other master asks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (w_next != r_state && w_next != IDLE) begin
      r_hold_cnt <= '0;
    end else if (r_state != IDLE && !w_hold_exp) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter_2m8s.sv
module tb_bus_arbiter_2m8s;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_wr, m1_req, m1_wr;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [31:0]       m0_dout, m1_dout;
  logic              m0_grant, m1_grant, s_wr, rd_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_din;
  logic [7:0]        s_sel;
  logic [2:0]        m_rsel;

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter_2m8s #(.ADDR_W(ADDR_W), .HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din), .s_sel(s_sel),
    .m_rsel(m_rsel), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // Advance one edge and let registered outputs settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = 16'h1234; m1_addr = 16'h4321; m0_dout = 32'h1; m1_dout = 32'h2;
    tick(); tick(); tick();
    n_vec++; if (m0_grant !== 1'b0) begin n_err++; $display("FAIL rst_m0_grant got %b want 0", m0_grant); end
    n_vec++; if (m1_grant !== 1'b0) begin n_err++; $display("FAIL rst_m1_grant got %b want 0", m1_grant); end
    n_vec++; if (s_sel !== 8'h00) begin n_err++; $display("FAIL rst_s_sel got %h want 00", s_sel); end
    n_vec++; if (s_addr !== 16'h0 || s_din !== 32'h0 || s_wr !== 1'b0) begin n_err++; $display("FAIL rst_bus got %h/%h/%b want 0/0/0", s_addr, s_din, s_wr); end
    n_vec++; if (m_rsel !== 3'd0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd got %0d/%b want 0/0", m_rsel, rd_valid); end
    reset = 1'b0;
    #1;
    n_vec++; if (m0_grant !== 1'b0) begin n_err++; $display("FAIL post_rst_latency got %b want 0", m0_grant); end
    tick();
    // last_gnt resets to M1, so M0 wins the tie.
    n_vec++; if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin n_err++; $display("FAIL first_tie got %b%b want 10", m0_grant, m1_grant); end
  endtask

  task automatic test_read();
    m1_req = 1'b0; m0_wr = 1'b0; m0_addr = 16'h6000;
    #1;
    n_vec++; if (s_sel !== 8'b0000_1000) begin n_err++; $display("FAIL rd_s_sel got %b want 00001000", s_sel); end
    n_vec++; if (s_wr !== 1'b0 || s_addr !== 16'h6000) begin n_err++; $display("FAIL rd_bus got %b/%h want 0/6000", s_wr, s_addr); end
    tick();
    n_vec++; if (m_rsel !== 3'd3 || rd_valid !== 1'b1) begin n_err++; $display("FAIL rd_steer got %0d/%b want 3/1", m_rsel, rd_valid); end
  endtask

  task automatic test_write();
    m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'hE004; m1_dout = 32'hDEADBEEF;
    #1;
    // Owner dropped req: still GNT0 but no select and no write strobe.
    n_vec++; if (s_sel !== 8'h00 || s_wr !== 1'b0) begin n_err++; $display("FAIL drop_sel got %h/%b want 00/0", s_sel, s_wr); end
    tick();
    n_vec++; if (m1_grant !== 1'b1 || m0_grant !== 1'b0) begin n_err++; $display("FAIL wr_grant got %b%b want 01", m0_grant, m1_grant); end
    n_vec++; if (s_sel !== 8'b1000_0000 || s_wr !== 1'b1) begin n_err++; $display("FAIL wr_sel got %b/%b want 10000000/1", s_sel, s_wr); end
    n_vec++; if (s_din !== 32'hDEADBEEF || s_addr !== 16'hE004) begin n_err++; $display("FAIL wr_data got %h/%h want deadbeef/e004", s_din, s_addr); end
    tick();
    n_vec++; if (rd_valid !== 1'b0 || m_rsel !== 3'd3) begin n_err++; $display("FAIL wr_no_rd got %b/%0d want 0/3", rd_valid, m_rsel); end
  endtask

  task automatic test_handover();
    m1_wr = 1'b0; m1_req = 1'b0;
    tick();
    n_vec++; if (m0_grant !== 1'b0 || m1_grant !== 1'b0 || s_din !== 32'h0) begin n_err++; $display("FAIL idle got %b%b/%h want 00/0", m0_grant, m1_grant, s_din); end
    // last_gnt = M1 now, so M0 wins.
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    n_vec++; if (m0_grant !== 1'b1) begin n_err++; $display("FAIL tie_m0 got %b want 1", m0_grant); end
    tick();
    n_vec++; if (m0_grant !== 1'b1) begin n_err++; $display("FAIL hold_m0 got %b want 1", m0_grant); end
    m0_req = 1'b0;
    tick();
    n_vec++; if (m1_grant !== 1'b1 || m0_grant !== 1'b0) begin n_err++; $display("FAIL direct_handover got %b%b want 01", m0_grant, m1_grant); end
    m1_req = 1'b0;
    tick();
    n_vec++; if (m1_grant !== 1'b0 || m0_grant !== 1'b0) begin n_err++; $display("FAIL back_idle got %b%b want 00", m0_grant, m1_grant); end
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    n_vec++; if (m0_grant !== 1'b1) begin n_err++; $display("FAIL rereq_m0 got %b want 1", m0_grant); end
    // Now last_gnt = M0: next tie from IDLE goes to M1.
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    n_vec++; if (m1_grant !== 1'b1) begin n_err++; $display("FAIL alt_tie got %b want 1", m1_grant); end
  endtask

  task automatic test_rsel_handover();
    // Currently GNT1; hand back to M0 then do the read handover.
    m0_wr = 1'b0; m1_wr = 1'b0; m0_addr = 16'h4000; m1_addr = 16'hA000;
    m1_req = 1'b0;
    tick();
    m1_req = 1'b1;
    n_vec++; if (m0_grant !== 1'b1 || s_sel !== 8'b0000_0100) begin n_err++; $display("FAIL m0_rd2 got %b/%b want 1/00000100", m0_grant, s_sel); end
    tick();
    m0_req = 1'b0;
    #1;
    n_vec++; if (m_rsel !== 3'd2 || rd_valid !== 1'b1) begin n_err++; $display("FAIL hand_rsel2 got %0d/%b want 2/1", m_rsel, rd_valid); end
    tick();
    n_vec++; if (m1_grant !== 1'b1 || s_sel !== 8'b0010_0000) begin n_err++; $display("FAIL m1_rd5 got %b/%b want 1/00100000", m1_grant, s_sel); end
    n_vec++; if (m_rsel !== 3'd2) begin n_err++; $display("FAIL rsel_hold got %0d want 2", m_rsel); end
    tick();
    n_vec++; if (m_rsel !== 3'd5 || rd_valid !== 1'b1) begin n_err++; $display("FAIL hand_rsel5 got %0d/%b want 5/1", m_rsel, rd_valid); end
    tick();
    n_vec++; if (m_rsel !== 3'd5 || rd_valid !== 1'b1) begin n_err++; $display("FAIL rd_back_to_back got %0d/%b want 5/1", m_rsel, rd_valid); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    n_vec++; if (rd_valid !== 1'b0 || m_rsel !== 3'd0) begin n_err++; $display("FAIL mid_rst_rd got %b/%0d want 0/0", rd_valid, m_rsel); end
    n_vec++; if (m1_grant !== 1'b0 || s_sel !== 8'h00) begin n_err++; $display("FAIL mid_rst_bus got %b/%h want 0/00", m1_grant, s_sel); end
  endtask

  task automatic test_hold_limit();
    // Comes out of reset with both requesting: last_gnt = M1, M0 first.
    m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b1; m1_wr = 1'b1;
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
`ifdef BUS_HOLD_LIMIT_EN
      if (c <= 4 || c >= 9) begin
        n_vec++; if (m0_grant !== 1'b1) begin n_err++; $display("FAIL hold_m0_c%0d got %b want 1", c, m0_grant); end
      end else begin
        n_vec++; if (m1_grant !== 1'b1) begin n_err++; $display("FAIL hold_m1_c%0d got %b want 1", c, m1_grant); end
      end
`else
      n_vec++; if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin n_err++; $display("FAIL starve_c%0d got %b%b want 10", c, m0_grant, m1_grant); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_handover();
    test_rsel_handover();
    test_reset_mid();
    test_hold_limit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
